// File: rtl/fifo_pkg.sv
// fifo_pkg: shared read-mode enum and pointer-width helper for the FIFO family
package fifo_pkg;
    typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port RAM, synchronous write, asynchronous read, no reset
module fifo_mem #(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATAWIDTH-1:0]     wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATAWIDTH-1:0]     rdata
);
    logic [DATAWIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_ext.sv
// fifo_ext: single-clock FIFO with std/FWFT read, occupancy, thresholds, sticky errors and flush
module fifo_ext
    import fifo_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH = 4,
    parameter int FWFT = 0,
    parameter int AF_TH = DEPTH - 1,
    parameter int AE_TH = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   wr_en,
    input  logic [DATAWIDTH-1:0]   wr_data,
    input  logic                   rd_en,
    output logic [DATAWIDTH-1:0]   rd_data,
    input  logic                   flush,
    input  logic                   clr_err,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int PW = ptr_w(DEPTH);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "fifo_ext: DEPTH must be a power of two >= 2");
    end
    if (AF_TH < 1 || AF_TH > DEPTH) begin : g_bad_af
        $fatal(1, "fifo_ext: AF_TH out of range 1..DEPTH");
    end
    if (AE_TH < 0 || AE_TH > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "fifo_ext: AE_TH out of range 0..DEPTH-1");
    end

    logic [PW-1:0] wptr, rptr;
    logic [DATAWIDTH-1:0] head;
    logic wr_acc, rd_acc;

    assign count        = wptr - rptr;
    assign full         = count == PW'(DEPTH);
    assign empty        = count == '0;
    assign almost_full  = count >= PW'(AF_TH);
    assign almost_empty = count <= PW'(AE_TH);
    assign wr_acc       = wr_en & ~full & ~flush;
    assign rd_acc       = rd_en & ~empty & ~flush;

    fifo_mem #(.DATAWIDTH(DATAWIDTH), .DEPTH(DEPTH)) u_mem (
        .clk  (clk),
        .we   (wr_acc),
        .waddr(wptr[PW-2:0]),
        .wdata(wr_data),
        .raddr(rptr[PW-2:0]),
        .rdata(head)
    );

    // a new error event in the same cycle wins over clr_err
    always_ff @(posedge clk or posedge resetn)
        if (resetn) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wptr      <= flush ? '0 : wptr + PW'(wr_acc);
            rptr      <= flush ? '0 : rptr + PW'(rd_acc);
            overflow  <= (wr_en & full & ~flush) | (overflow & ~clr_err);
            underflow <= (rd_en & empty & ~flush) | (underflow & ~clr_err);
        end

    if (MODE == FIFO_FWFT) begin : g_fwft
        assign rd_data = head;
    end else begin : g_std
        logic [DATAWIDTH-1:0] rd_q;
        always_ff @(posedge clk or posedge resetn)
            if (resetn) rd_q <= '0;
            else if (rd_acc) rd_q <= head;
        assign rd_data = rd_q;
    end
endmodule

// File: doc/fifo_ext.md
# fifo_ext

Parametrised single-clock FIFO that extends the basic full/empty FIFO. It adds a selectable read mode (standard registered read or first-word-fall-through), an occupancy count, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and a synchronous flush. It is the buffering primitive between producer and consumer stages in the same clock domain.

## Interface
- DATAWIDTH, 8, word width in bits.
- DEPTH, 4, number of entries; must be a power of two and ≥2.
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through.
- AF_TH, DEPTH-1, almost_full threshold; legal range 1..DEPTH.
- AE_TH, 1, almost_empty threshold; legal range 0..DEPTH-1.
- Derived: ADDRW = $clog2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  reset resetn, asynchronous, active-high.
- wr_en  in  1  write request.
- wr_data  in  DATAWIDTH  write word.
- rd_en  in  1  read/pop request.
- rd_data  out  DATAWIDTH  read word.
- flush  in  1  synchronous clear of contents.
- clr_err  in  1  synchronous clear of the sticky error flags.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_TH.
- almost_empty  out  1  count ≤ AE_TH.
- count  out  ADDRW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; a write was attempted while full.
- underflow  out  1  sticky; a read was attempted while empty.

## Operation
- Pointers wptr and rptr are ADDRW+1 bits wide and wrap modulo 2·DEPTH. The RAM address is ptr[ADDRW-1:0]. count = wptr − rptr, computed modulo 2^(ADDRW+1).
- Write acceptance: wr_acc = wr_en & ~full & ~flush. An accepted write stores wr_data at wptr and increments wptr.
- Read acceptance: rd_acc = rd_en & ~empty & ~flush. An accepted read increments rptr.
- Both acceptance conditions use flag values from before the edge:
  - A write to a full FIFO is rejected even if a read is accepted in the same cycle.
  - A read from an empty FIFO is rejected even if a write is accepted in the same cycle.
- Simultaneous accepted read and write leaves count unchanged and preserves word order.
- FWFT=0: on rd_acc, rd_data is registered with mem[rptr] and is valid the cycle after rd_en. Otherwise rd_data holds its last value.
- FWFT=1: rd_data = mem[rptr] combinationally and is valid whenever empty=0. rd_acc pops the head word. rd_data is don't-care while empty.
- flush: wptr and rptr are set to 0 at the edge and the FIFO becomes empty. flush beats wr_en and rd_en in the same cycle. It does not clear overflow or underflow. In FWFT=0, rd_data is unchanged.
- Error flags:
  - overflow is set on wr_en & full & ~flush.
  - underflow is set on rd_en & empty & ~flush.
  - clr_err clears both flags. A set in the same cycle wins over clr_err.
- All status outputs are combinational from the registered pointers and error bits. None depends combinationally on wr_en or rd_en.
- Memory contents are not reset.

## Timing
- Reset values: count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, rd_data=0 (FWFT=0). Both pointers are 0.
- Reset asserted mid-operation clears all of the above immediately, without waiting for a clock edge.
- A write at edge N is reflected in count and flags from edge N. In FWFT=1, that word appears on rd_data in cycle N+1 if the FIFO was empty.
- Read latency: 1 cycle for FWFT=0, 0 cycles for FWFT=1.
- Throughput: one write and one read per cycle.

## Structure
- Shared package fifo_pkg holds:
  - enum fifo_mode_e {FIFO_STD, FIFO_FWFT};
  - function ptr_w(depth) returning $clog2(depth)+1.
- Elaboration-time assertions check the DEPTH, AF_TH and AE_TH legality rules.
- Sub-module fifo_mem: simple dual-port RAM with synchronous write and asynchronous read. It has no reset. fifo_ext wraps the pointers, flags and read register around it.

## Test plan
All scenarios use DATAWIDTH=8, DEPTH=4, AF_TH=3, AE_TH=1.
- Reset: hold resetn=1 for 2 cycles, then release → count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rd_data=0x00.
- Fill and overflow (FWFT=0): write 0xA1, 0xB2, 0xC3, 0xD4, 0xE5 back-to-back → count steps 1, 2, 3, 4; almost_full is set at count=3; full is set after 0xD4; 0xE5 is dropped and overflow=1. Then 4 reads → rd_data is 0xA1, 0xB2, 0xC3, 0xD4, each one cycle after its rd_en; 0xE5 never appears; empty=1 at the end.
- FWFT (FWFT=1): write 0x5A to an empty FIFO → next cycle empty=0 and rd_data=0x5A with no rd_en. Pulse rd_en once → empty=1, count=0.
- Wrap-around and concurrency: stream 0x00–0x09 with reads overlapping writes, holding count at 2 during the overlap → output order is exactly 0x00–0x09; count stays 2 during every simultaneous read+write cycle; pointers cross the 2·DEPTH wrap without error.
- Underflow and clear: rd_en on empty → underflow=1, count=0, rd_data unchanged. clr_err together with a repeated empty rd_en → underflow stays 1. clr_err alone → underflow=0.
- Flush and reset: at count=3, assert flush with wr_en=1 and wr_data=0x77 → next cycle count=0, empty=1, the write is dropped, and sticky flags are retained. Assert resetn mid-stream between clock edges → all outputs take reset values before the next edge.
